// File: rtl/instruction_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_if
//   Instruction-memory fetch bus: single outstanding request, response with
//   a valid strobe.
//
//   req    master->slave  fetch request, held until rvalid
//   addr   master->slave  fetch address, stable while req is high
//   rvalid slave->master  response valid
//   rdata  slave->master  instruction word, valid with rvalid
// ----------------------------------------------------------------------------
interface instruction_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input rvalid, rdata);
  modport slave  (input req, addr, output rvalid, rdata);
endinterface

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//   IF stage of the RV32IM pipeline. Owns the PC, fetches instructions over
//   the imem bus (one request outstanding) and drives the IF/ID register.
//   A one-entry skid buffer absorbs a response that arrives while decode is
//   stalled on a valid instruction. Redirects flush IF/ID and restart fetch;
//   a response still in flight at redirect time is drained and dropped.
//
//   Ports
//     clk, rst_n       clock (rising edge), asynchronous active-low reset
//     imem             fetch bus (master side)
//     id_stall         decode cannot accept; IF/ID holds
//     redirect_valid   flush and restart fetch at redirect_pc
//     redirect_pc      new fetch target
//     id_valid         IF/ID slot holds a real instruction
//     id_inst          instruction to decode (NOP_INST when empty)
//     id_pc            address of id_inst
//     id_pc_plus4      id_pc + 4, link value for JAL/JALR
//     fetch_misalign   (FETCH_MISALIGN_EN only) last redirect target had
//                      nonzero low bits
//
//   Build option
//     FETCH_MISALIGN_EN  when defined, redirect targets are forced to word
//                        alignment and fetch_misalign flags misaligned ones;
//                        otherwise redirect_pc is loaded unmodified.
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  instruction_fetch_unit_if.master imem,
  input  logic                     id_stall,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     id_valid,
  output logic [31:0]              id_inst,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_pc_plus4
`ifdef FETCH_MISALIGN_EN
  ,
  output logic                     fetch_misalign
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] drop_addr, drop_addr_n;   // address of the response being drained
  logic [31:0] skid_inst, skid_inst_n;
  logic [31:0] skid_pc, skid_pc_n;
  logic        id_valid_n;
  logic [31:0] id_inst_n, id_pc_n, id_pc_plus4_n;
  logic [31:0] target;
  logic        slot_free;

`ifdef FETCH_MISALIGN_EN
  assign target = {redirect_pc[31:2], 2'b00};
`else
  assign target = redirect_pc;
`endif

  assign slot_free = !id_valid || !id_stall;

  // The request drops in the response cycle itself, so with 1-cycle memory
  // the next request starts right after: one instruction every two cycles.
  // In DROP the old request stays visible until its response is drained.
  assign imem.req  = ((state == FETCH) || (state == DROP)) && !imem.rvalid;
  assign imem.addr = (state == DROP) ? drop_addr : pc;

  // NOTE: every signal gets its hold value first so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    drop_addr_n   = drop_addr;
    skid_inst_n   = skid_inst;
    skid_pc_n     = skid_pc;
    id_valid_n    = id_valid;
    id_inst_n     = id_inst;
    id_pc_n       = id_pc;
    id_pc_plus4_n = id_pc_plus4;

    // Decode took the slot and nothing replaces it: present a bubble.
    if (!id_stall) begin
      id_valid_n = 1'b0;
      id_inst_n  = NOP_INST;
    end

    if (redirect_valid) begin
      id_valid_n  = 1'b0;
      id_inst_n   = NOP_INST;
      pc_n        = target;
      skid_inst_n = '0;
      skid_pc_n   = '0;
      case (state)
        FETCH: begin
          if (!imem.rvalid) begin
            state_n     = DROP;
            drop_addr_n = pc;
          end
        end
        DROP: begin
          if (imem.rvalid) state_n = FETCH;
        end
        default: state_n = FETCH;
      endcase
    end else begin
      case (state)
        IDLE: state_n = FETCH;
        FETCH: begin
          if (imem.rvalid) begin
            pc_n = pc + 32'd4;
            if (slot_free) begin
              id_valid_n    = 1'b1;
              id_inst_n     = imem.rdata;
              id_pc_n       = pc;
              id_pc_plus4_n = pc + 32'd4;
            end else begin
              skid_inst_n = imem.rdata;
              skid_pc_n   = pc;
              state_n     = HOLD;
            end
          end
        end
        HOLD: begin
          if (!id_stall) begin
            id_valid_n    = 1'b1;
            id_inst_n     = skid_inst;
            id_pc_n       = skid_pc;
            id_pc_plus4_n = skid_pc + 32'd4;
            state_n       = FETCH;
          end
        end
        DROP: begin
          if (imem.rvalid) state_n = FETCH;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      drop_addr   <= '0;
      // NOTE: the skid entry is a single register pair, so it is reset along
      // with everything else; a deep buffer would normally be left unreset.
      skid_inst   <= '0;
      skid_pc     <= '0;
      id_valid    <= 1'b0;
      id_inst     <= NOP_INST;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      drop_addr   <= drop_addr_n;
      skid_inst   <= skid_inst_n;
      skid_pc     <= skid_pc_n;
      id_valid    <= id_valid_n;
      id_inst     <= id_inst_n;
      id_pc       <= id_pc_n;
      id_pc_plus4 <= id_pc_plus4_n;
    end
  end

`ifdef FETCH_MISALIGN_EN
  // Every redirect re-evaluates the flag, so an aligned target clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              fetch_misalign <= 1'b0;
    else if (redirect_valid) fetch_misalign <= |redirect_pc[1:0];
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Directed scenarios followed by a randomized phase. A memory responder
//   with configurable latency serves the fetch bus; a reference model tracks
//   the program-order address stream that decode must observe and the
//   IF/ID hold/flush rules. Build with FETCH_MISALIGN_EN to cover the flag.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_inst, id_pc, id_pc_plus4;
`ifdef FETCH_MISALIGN_EN
  logic        fetch_misalign;
`endif

  instruction_fetch_unit_if imem ();

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
`ifdef FETCH_MISALIGN_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instruction memory contents: distinct per address, 0x33 at address 0.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  // ---------------------------------------------------------------- memory
  int          mem_lat = 1;      // 0 = random 1..3 cycles
  logic        inject  = 1'b0;   // spurious rvalid while in reset/IDLE
  logic        mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;
  logic        rv_next  = 1'b0;
  logic [31:0] rd_next  = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_busy = 1'b0;
      mem_cnt  = 0;
      rv_next  = inject;
      rd_next  = 32'hDEAD_BEEF;
    end else begin
      rv_next = 1'b0;
      if (imem.rvalid === 1'b1) begin
        mem_busy = 1'b0;
      end else if (mem_busy) begin
        check("mem_req_held", imem.req, 1);
        check("mem_addr_stable", imem.addr, mem_addr);
      end else if (imem.req === 1'b1) begin
        mem_busy = 1'b1;
        mem_addr = imem.addr;
        mem_cnt  = (mem_lat == 0) ? int'($urandom_range(3, 1)) : mem_lat;
      end
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          rv_next = 1'b1;
          rd_next = mem_word(mem_addr);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    imem.rvalid = rv_next;
    imem.rdata  = rd_next;
  end

  // ---------------------------------------------------------- reference
  // Decode must see the program-order stream: consecutive words from the
  // last redirect target (or RESET_PC), each exactly once, never the data
  // of a flushed fetch. A stalled slot holds; a redirect empties the slot.
  logic [31:0] exp_pc = RESET_PC;
  int          consumed = 0;
  logic        pv = 1'b0, ps = 1'b0, pr = 1'b0;
  logic [31:0] ppc = '0, pinst = '0, pp4 = '0;
`ifdef FETCH_MISALIGN_EN
  logic        exp_mis = 1'b0;
`endif

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc = RESET_PC;
      pv = 1'b0; ps = 1'b0; pr = 1'b0;
`ifdef FETCH_MISALIGN_EN
      exp_mis = 1'b0;
`endif
    end else begin
      if (pr) check("flush_valid", id_valid, 0);
      if (pv && ps && !pr) begin
        check("hold_valid", id_valid, 1);
        check("hold_pc", id_pc, ppc);
        check("hold_inst", id_inst, pinst);
        check("hold_pc4", id_pc_plus4, pp4);
      end
      if (id_valid === 1'b0) check("empty_nop", id_inst, NOP_INST);
`ifdef FETCH_MISALIGN_EN
      check("misalign_flag", fetch_misalign, exp_mis);
`endif
      if (redirect_valid) begin
`ifdef FETCH_MISALIGN_EN
        exp_pc  = redirect_pc & ~32'h3;
        exp_mis = (redirect_pc[1:0] != 2'b00);
`else
        exp_pc  = redirect_pc;
`endif
      end else if (id_valid === 1'b1 && !id_stall) begin
        check("stream_pc", id_pc, exp_pc);
        check("stream_inst", id_inst, mem_word(exp_pc));
        check("stream_pc4", id_pc_plus4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      pv = id_valid; ps = id_stall; pr = redirect_valid;
      ppc = id_pc; pinst = id_inst; pp4 = id_pc_plus4;
    end
  end

  // Wait (bounded) at negedges until a request to address a is visible.
  task automatic wait_req(input logic [31:0] a, input int budget, input string tag);
    int n = 0;
    while (!(imem.req === 1'b1 && imem.addr === a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, (imem.req === 1'b1 && imem.addr === a)}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    int start_consumed;
    logic [31:0] r;
    rst_n = 1'b0; id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req", imem.req, 0);
    check("rst_addr", imem.addr, RESET_PC);
    check("rst_valid", id_valid, 0);
    check("rst_inst", id_inst, NOP_INST);
    check("rst_pc", id_pc, 0);
    check("rst_pc4", id_pc_plus4, 0);

    // First fetch with 1-cycle memory
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); check("idle_req", imem.req, 0);
    @(negedge clk); check("first_req", imem.req, 1); check("first_addr", imem.addr, 32'h0);
    @(negedge clk); check("gap_req", imem.req, 0);
    @(negedge clk);
    check("first_valid", id_valid, 1);
    check("first_inst", id_inst, 32'h0000_0033);
    check("first_pc", id_pc, 32'h0);
    check("first_pc4", id_pc_plus4, 32'h4);
    check("second_addr", imem.addr, 32'h4);
    @(negedge clk);

    // Stall three cycles across the 0x8 response
    @(posedge clk); #1 id_stall = 1'b1;
    @(negedge clk); check("stall_pc4", id_pc, 32'h4); check("stall_addr8", imem.addr, 32'h8);
    @(negedge clk);
    @(negedge clk);
    check("hold_req", imem.req, 0); check("hold_id_pc", id_pc, 32'h4); check("hold_id_valid", id_valid, 1);
    @(posedge clk); #1 id_stall = 1'b0;
    @(negedge clk); check("release_pc", id_pc, 32'h4);
    @(negedge clk);
    check("skid_pc", id_pc, 32'h8); check("skid_valid", id_valid, 1);
    check("resume_req", imem.req, 1); check("resume_addr", imem.addr, 32'hC);

    // Redirect while a 3-cycle request to 0x10 is outstanding
    @(posedge clk); #1 mem_lat = 3;
    @(negedge clk);
    wait_req(32'h10, 10, "req_0x10");
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h100; mem_lat = 1;
    @(negedge clk); check("rd_addr_old", imem.addr, 32'h10);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("drop_valid", id_valid, 0); check("drop_req", imem.req, 1); check("drop_addr", imem.addr, 32'h10);
    @(negedge clk); check("drop_rsp_req", imem.req, 0);
    @(negedge clk);
    check("new_req", imem.req, 1); check("new_addr", imem.addr, 32'h100); check("new_valid", id_valid, 0);

    // Redirect, stall and rvalid in the same cycle
    @(posedge clk); #1 id_stall = 1'b1;
    @(negedge clk);
    @(negedge clk); check("busy_pc", id_pc, 32'h100); check("busy_valid", id_valid, 1);
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    @(posedge clk); #1 redirect_valid = 1'b0; id_stall = 1'b0;
    @(negedge clk);
    check("prio_valid", id_valid, 0); check("prio_inst", id_inst, NOP_INST);
    check("prio_req", imem.req, 1); check("prio_addr", imem.addr, 32'h200);

    // PC wrap at the top of the address space
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    wait_req(32'hFFFF_FFFC, 10, "wrap_top");
    @(negedge clk);
    wait_req(32'h0, 10, "wrap_zero");

    // Misaligned redirect target
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
`ifdef FETCH_MISALIGN_EN
    check("misalign_set", fetch_misalign, 1);
    wait_req(32'h100, 10, "misalign_addr");
`else
    wait_req(32'h102, 10, "unaligned_addr");
`endif
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
`ifdef FETCH_MISALIGN_EN
    check("misalign_clr", fetch_misalign, 0);
`endif
    wait_req(32'h200, 10, "realign_addr");

    // Reset during an outstanding request, then a stray rvalid in IDLE
    @(posedge clk); #1 mem_lat = 3; redirect_valid = 1'b1; redirect_pc = 32'h300;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    wait_req(32'h300, 10, "req_0x300");
    @(posedge clk); #1 rst_n = 1'b0; inject = 1'b1;
    @(negedge clk);
    check("mid_rst_req", imem.req, 0); check("mid_rst_addr", imem.addr, RESET_PC);
    check("mid_rst_valid", id_valid, 0); check("mid_rst_pc", id_pc, 0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1; inject = 1'b0; mem_lat = 1;
    @(negedge clk); check("stray_idle_valid", id_valid, 0);
    @(negedge clk);
    check("stray_req", imem.req, 1); check("stray_addr", imem.addr, 32'h0); check("stray_valid", id_valid, 0);
    @(negedge clk);
    @(negedge clk); check("after_rst_inst", id_inst, 32'h0000_0033); check("after_rst_valid", id_valid, 1);

    // Randomized phase
    mem_lat = 0;
    start_consumed = consumed;
    repeat (400) begin
      @(posedge clk); #1;
      id_stall       = ($urandom_range(99) < 30);
      redirect_valid = ($urandom_range(99) < 6);
      r = $urandom;
      case ($urandom_range(2))
        0:       redirect_pc = r;
        1:       redirect_pc = 32'hFFFF_FFF0 | (r & 32'hF);
        default: redirect_pc = r & 32'h0000_0FFC;
      endcase
    end
    @(posedge clk); #1 id_stall = 1'b0; redirect_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("progress", {31'd0, (consumed - start_consumed >= 30)}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
IF stage of the RV32IM pipeline. Owns the PC, fetches 32-bit instructions from instruction memory over a single-outstanding request/response interface, and drives the IF/ID pipeline register. Its outputs feed decode and the control unit, which consumes opcode bits id_inst[6:2]. Supports decode stall (hazard unit) and redirect (taken branch/JAL/JALR from EX).

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INST, 32'h0000_0013, value driven on id_inst when the slot is empty (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request, held high until imem_rvalid
imem_addr  out  32  fetch address, stable while imem_req=1
imem_rvalid  in  1  response valid, at least 1 cycle after request start
imem_rdata  in  32  instruction word, valid with imem_rvalid
id_stall  in  1  decode cannot accept; hold IF/ID contents
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  32  new fetch target
id_valid  out  1  IF/ID slot holds a real instruction
id_inst  out  32  instruction to decode/control unit
id_pc  out  32  address of id_inst
id_pc_plus4  out  32  id_pc+4 (JAL/JALR link value)

Behaviour:
- Reset (asynchronous, rst_n=0): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_inst=NOP_INST, id_pc=0, id_pc_plus4=0, skid buffer empty.
- States: IDLE, FETCH, HOLD, DROP.
- IDLE: entered only from reset; first clock after rst_n release moves to FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_rvalid:
  - If the IF/ID slot is free (id_valid=0 or id_stall=0), load id_inst=imem_rdata, id_pc=pc, id_pc_plus4=pc+4, id_valid=1. Set pc=pc+4 and stay in FETCH. imem_req drops for one cycle, and the next request starts the cycle after.
  - Else capture {rdata,pc} in the skid buffer, set pc=pc+4, go to HOLD with imem_req=0.
- HOLD: when id_stall=0, IF/ID loads from the skid buffer with id_valid=1, and the state goes to FETCH.
- Throughput: one instruction per 2 cycles with 1-cycle memory latency.
- Decode handoff: if id_stall=0 and no new instruction arrives, id_valid goes to 0 and id_inst to NOP_INST. If id_stall=1, all id_* outputs hold.
- Redirect (redirect_valid=1) has highest priority over stall, rvalid and skid:
  - id_valid<=0, id_inst<=NOP_INST, skid buffer cleared, pc<=redirect_pc.
  - If a request is outstanding and imem_rvalid=0 this cycle, go to DROP. imem_req and imem_addr stay on the old address until imem_rvalid. That response is discarded, then the state goes to FETCH at the new pc.
  - If imem_rvalid=1 in the same cycle, the data is discarded and the state goes straight to FETCH.
  - In HOLD or IDLE, go to FETCH.
  - A second redirect while in DROP updates pc and stays in DROP.
- Arithmetic: pc+4 is modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- redirect_pc[1:0] is passed through unmodified (see optional feature).
- Reset asserted mid-request: all state is cleared immediately, and any later imem_rvalid in IDLE is ignored.

Optional Feature:
Macro: FETCH_MISALIGN_EN
- Enabled: adds output fetch_misalign (1 bit, reset 0). A redirect with redirect_pc[1:0]!=0 sets fetch_misalign=1 registered on that edge. pc loads redirect_pc & ~32'h3, and fetch proceeds. fetch_misalign clears on the next redirect_valid whose target is aligned.
- Disabled: no port. The low bits are loaded as given.

Test Plan:
- Reset release, 1-cycle memory returning 32'h00000033 at 0x0 → imem_addr=0x0 first. id_valid=1, id_inst=0x00000033, id_pc=0, id_pc_plus4=4 one cycle after rvalid. Next request address is 0x4.
- id_stall=1 held for 3 cycles while the response for 0x8 arrives → id_* hold the 0x4 instruction, HOLD entered, imem_req=0. Stall release → id_pc=0x8 next cycle, fetch resumes at 0xC.
- Redirect to 0x100 while a 3-cycle-latency request to 0x10 is outstanding → id_valid=0 next cycle, imem_addr stays 0x10 until rvalid, the 0x10 data is never presented. Next request is 0x100.
- redirect_valid, id_stall and imem_rvalid all high in one cycle → redirect wins, id_valid=0, next imem_addr=redirect_pc.
- RESET_PC=32'hFFFF_FFFC → second fetch address is 0x0.
- FETCH_MISALIGN_EN build, redirect to 0x102 → fetch_misalign=1, imem_addr=0x100. Later redirect to 0x200 → fetch_misalign=0.
